// File: rtl/camera_emu_pkg.sv
// camera_emu_pkg: shared types, colour-bar constants and noise helpers for camera_emulator.
package camera_emu_pkg;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} cam_state_e;

    typedef enum logic [1:0] {PAT_BARS, PAT_SOLID, PAT_TARGET, PAT_BLACK} pattern_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        pattern_e    pattern;
        logic [15:0] solid_rgb;
        logic [9:0]  target_x;
        logic [8:0]  target_y;
    } cam_cfg_t;

    function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

    // Fibonacci LFSR, taps 16/14/13/11, shifting towards the MSB
    function automatic logic [15:0] lfsr_next(input logic [15:0] n);
        return {n[14:0], n[15] ^ n[13] ^ n[12] ^ n[10]};
    endfunction

    // Flips the R, G and B LSBs of an RGB565 word
    function automatic logic [15:0] noise_mask(input logic [15:0] n);
        return {4'b0, n[0], 5'b0, n[1], 4'b0, n[2]};
    endfunction

endpackage

// File: rtl/camera_emu_if.sv
// camera_emu_if: OV7670-style camera pins (pclk, vsync, href, pixel byte).
//   master: the camera/emulator side drives every pin.
//   slave:  the receiver side (camera_read) samples every pin.
interface camera_emu_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] pixel;

    modport master (output pclk, vsync, href, pixel);
    modport slave  (input  pclk, vsync, href, pixel);
endinterface

// File: rtl/camera_emu_pattern.sv
// camera_emu_pattern: combinational test-pattern generator, (x, y, latched config) -> RGB565.
//   x, y  : pixel column and row inside the active area
//   cfg   : pattern select, solid colour and target position latched at frame start
//   rgb   : RGB565 colour of the pixel
module camera_emu_pattern
    import camera_emu_pkg::*;
#(
    parameter int          H_ACTIVE    = 320,
    parameter int          TARGET_SIZE = 32,
    parameter logic [15:0] TARGET_RGB  = 16'hF800
) (
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  cam_cfg_t    cfg,
    output logic [15:0] rgb
);
    localparam logic [9:0]  BAR_W = 10'(H_ACTIVE / 8);
    localparam logic [10:0] SIZE  = 11'(TARGET_SIZE);

    logic [9:0]  bar;
    logic [2:0]  bar_idx;
    logic [10:0] x11, y11, tx11, ty11;
    logic        hit;

    // 11-bit compares so a block near the right/bottom edge clips instead of wrapping
    always_comb begin
        bar     = x / BAR_W;
        bar_idx = (bar > 10'd7) ? 3'd7 : bar[2:0];
        x11     = {1'b0, x};
        y11     = {2'b0, y};
        tx11    = {1'b0, cfg.target_x};
        ty11    = {2'b0, cfg.target_y};
        hit     = x11 >= tx11 && x11 < tx11 + SIZE && y11 >= ty11 && y11 < ty11 + SIZE;
        rgb     = cfg.pattern == PAT_BARS   ? bar_rgb(bar_idx) :
                  cfg.pattern == PAT_SOLID  ? cfg.solid_rgb :
                  cfg.pattern == PAT_TARGET ? (hit ? TARGET_RGB : 16'h0000) : 16'h0000;
    end
endmodule

// File: rtl/camera_emulator.sv
// camera_emulator: OV7670-style camera transmitter producing RGB565 test frames.
//   system_clock_in / reset_n_in : system clock, asynchronous active-low reset
//   enable_in                    : allow new frames to start
//   pattern_sel_in, solid_rgb_in,
//   target_x_in, target_y_in     : frame configuration, latched at each frame start
//   cam (master)                 : pclk, vsync, href, pixel byte
//   frame_start_out              : one-cycle pulse with the vsync rise
//   frame_count_out              : frames started, wraps at 16 bits
// Build option: define CAMERA_EMU_NOISE_EN to XOR LFSR noise into the pixel LSBs.
module camera_emulator
    import camera_emu_pkg::*;
#(
    parameter int          PCLK_HALF   = 2,
    parameter int          H_ACTIVE    = 320,
    parameter int          H_BLANK     = 144,
    parameter int          V_ACTIVE    = 240,
    parameter int          V_SYNC      = 3,
    parameter int          V_BACK      = 17,
    parameter int          V_FRONT     = 10,
    parameter int          TARGET_SIZE = 32,
    parameter logic [15:0] TARGET_RGB  = 16'hF800
) (
    input  logic         system_clock_in,
    input  logic         reset_n_in,
    input  logic         enable_in,
    input  logic [1:0]   pattern_sel_in,
    input  logic [15:0]  solid_rgb_in,
    input  logic [9:0]   target_x_in,
    input  logic [8:0]   target_y_in,
    camera_emu_if.master cam,
    output logic         frame_start_out,
    output logic [15:0]  frame_count_out
);
    localparam int          L          = 2 * H_ACTIVE + H_BLANK;
    localparam logic [15:0] DIV_LAST   = 16'(PCLK_HALF - 1);
    localparam logic [15:0] H_LAST     = 16'(L - 1);
    localparam logic [15:0] HREF_END   = 16'(2 * H_ACTIVE);
    localparam logic [15:0] SYNC_LAST  = 16'(V_SYNC - 1);
    localparam logic [15:0] BACK_LAST  = 16'(V_BACK - 1);
    localparam logic [15:0] ACT_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] FRONT_LAST = 16'(V_FRONT - 1);

    cam_state_e  state, adv_state, nxt_state;
    logic [15:0] div, h, v, nxt_h, nxt_v, v_last;
    logic        pclk, tick, line_end, phase_end, start;
    logic        vsync_q, href_q, vsync_d, href_d;
    logic [7:0]  pixel_q, pixel_d;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [15:0] pat_rgb, noise, pix_rgb;
    cam_cfg_t    cfg;

    always_ff @(posedge system_clock_in or negedge reset_n_in)
        if (!reset_n_in) begin
            div  <= '0;
            pclk <= 1'b0;
        end else begin
            div  <= (div == DIV_LAST) ? '0 : div + 16'd1;
            pclk <= (div == DIV_LAST) ? ~pclk : pclk;
        end

    // every state and output change happens on the system cycle where pclk falls
    assign tick = pclk && div == DIV_LAST;

    always_ff @(posedge system_clock_in or negedge reset_n_in)
        if (!reset_n_in) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
        end else if (tick) begin
            state <= nxt_state;
            h     <= nxt_h;
            v     <= nxt_v;
        end

    // h counts pclk periods within a line, v counts lines within the current phase
    always_comb begin
        v_last    = state == VSYNC ? SYNC_LAST : state == VBACK ? BACK_LAST :
                    state == ACTIVE ? ACT_LAST : FRONT_LAST;
        line_end  = h == H_LAST;
        phase_end = line_end && v == v_last;
        adv_state = state;
        if (phase_end)
            case (state)
                VSYNC:   adv_state = VBACK;
                VBACK:   adv_state = ACTIVE;
                ACTIVE:  adv_state = VFRONT;
                VFRONT:  adv_state = IDLE;
                default: adv_state = state;
            endcase
        // IDLE is evaluated on the same tick it is entered, so frames run back to back
        start     = adv_state == IDLE && enable_in;
        nxt_state = adv_state;
        if (start)
            nxt_state = VSYNC;
        nxt_h     = (line_end || adv_state == IDLE) ? '0 : h + 16'd1;
        nxt_v     = (phase_end || adv_state == IDLE) ? '0 : line_end ? v + 16'd1 : v;
    end

    assign px = 10'(nxt_h >> 1);
    assign py = 9'(nxt_v);

    camera_emu_pattern #(
        .H_ACTIVE    (H_ACTIVE),
        .TARGET_SIZE (TARGET_SIZE),
        .TARGET_RGB  (TARGET_RGB)
    ) u_pattern (
        .x   (px),
        .y   (py),
        .cfg (cfg),
        .rgb (pat_rgb)
    );

`ifdef CAMERA_EMU_NOISE_EN
    logic [15:0] lfsr;

    // one step per pixel, on the low-byte tick; both bytes use the pre-advance state
    always_ff @(posedge system_clock_in or negedge reset_n_in)
        if (!reset_n_in)
            lfsr <= LFSR_SEED;
        else if (tick && href_d && nxt_h[0])
            lfsr <= lfsr_next(lfsr);

    assign noise = noise_mask(lfsr);
`else
    assign noise = '0;
`endif

    // outputs are decoded from the post-tick position so they register on the tick itself
    always_comb begin
        vsync_d = nxt_state == VSYNC;
        href_d  = nxt_state == ACTIVE && nxt_h < HREF_END;
        pix_rgb = pat_rgb ^ noise;
        pixel_d = !href_d ? 8'h00 : nxt_h[0] ? pix_rgb[7:0] : pix_rgb[15:8];
    end

    always_ff @(posedge system_clock_in or negedge reset_n_in)
        if (!reset_n_in) begin
            vsync_q         <= 1'b0;
            href_q          <= 1'b0;
            pixel_q         <= '0;
            frame_start_out <= 1'b0;
            frame_count_out <= '0;
            cfg             <= '0;
        end else begin
            frame_start_out <= tick && start;
            if (tick) begin
                vsync_q <= vsync_d;
                href_q  <= href_d;
                pixel_q <= pixel_d;
                if (start) begin
                    cfg             <= '{pattern_e'(pattern_sel_in), solid_rgb_in, target_x_in, target_y_in};
                    frame_count_out <= frame_count_out + 16'd1;
                end
            end
        end

    assign cam.pclk  = pclk;
    assign cam.vsync = vsync_q;
    assign cam.href  = href_q;
    assign cam.pixel = pixel_q;
endmodule
